// File: rtl/memory_pkg.sv
// Shared types and constants for the backing-memory responder and its cache-side benches.
package memory_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] POISON = 32'hDEADBEEF;
  localparam int DEFAULT_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;
endpackage

// File: rtl/memory_responder_ram.sv
// Single-port synchronous RAM, DEPTH_WORDS x WORD_W, write enable and registered read.
module memory_responder_ram
  import memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = 10
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Multi-cycle memory responder: accepts one word access, completes it after LATENCY cycles
// and pulses respReady. Define MEMORY_RESPONDER_ADDR_CHECK_EN to flag out-of-range addresses.
module memory_responder
  import memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = DEFAULT_LATENCY,
  parameter int ADDR_BITS   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqReadEnable,
  input  logic              reqWriteEnable,
  input  logic [31:0]       reqAddress,
  input  logic [WORD_W-1:0] reqDataIn,
  output logic [WORD_W-1:0] respDataOut,
  output logic              respReady,
  output logic              respError
);

  state_t state, stateNext;
  logic [7:0] count, countNext;
  logic [ADDR_BITS-1:0] idxLatch;
  logic [WORD_W-1:0] dataLatch, ramRdata;
  logic opWrite, errLatch, outOfRange;
  logic ramEn, ramWe, accept;

`ifdef MEMORY_RESPONDER_ADDR_CHECK_EN
  assign outOfRange = |reqAddress[31:ADDR_BITS+2];
  assign respError  = (state == DONE) & errLatch;
  wire unusedAddrBits = ^reqAddress[1:0];
`else
  assign outOfRange = 1'b0;
  assign respError  = 1'b0;
  wire unusedAddrBits = ^{reqAddress[31:ADDR_BITS+2], reqAddress[1:0]};
`endif

  assign accept = (state == IDLE) & (reqReadEnable | reqWriteEnable);

  always_comb begin
    stateNext = state;
    countNext = count;
    ramEn     = 1'b0;
    ramWe     = 1'b0;
    case (state)
      IDLE: if (accept) begin
        stateNext = BUSY;
        countNext = 8'(LATENCY - 1);
      end
      BUSY: begin
        if (count != 8'd0) countNext = count - 8'd1;
        else begin
          ramEn     = 1'b1;
          ramWe     = opWrite & ~errLatch;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 8'd0;
      idxLatch  <= '0;
      dataLatch <= '0;
      opWrite   <= 1'b0;
      errLatch  <= 1'b0;
    end else begin
      state <= stateNext;
      count <= countNext;
      if (accept) begin
        idxLatch  <= reqAddress[ADDR_BITS+1:2];
        dataLatch <= reqDataIn;
        opWrite   <= reqWriteEnable;  // both enables high counts as a write
        errLatch  <= outOfRange;
      end
    end
  end

  // Gate with reset so an access aborted at its final edge never commits.
  memory_responder_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_BITS  (ADDR_BITS)
  ) uRam (
    .clk  (clk),
    .en   (ramEn & ~reset),
    .we   (ramWe & ~reset),
    .addr (idxLatch),
    .wdata(dataLatch),
    .rdata(ramRdata)
  );

  // DONE is the single ready cycle; outside it the data bus sits at zero.
  assign respReady   = (state == DONE);
  assign respDataOut = (state != DONE) ? '0 :
                       opWrite          ? dataLatch :
                       errLatch         ? POISON : ramRdata;

endmodule
